// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Purpose:
//   Instruction fetch sequencer for a program ROM with a registered read port.
//   Each instruction is fetched in three steps:
//     S_REQ  issue the ROM read at pc
//     S_CAP  capture the returned word
//     S_OUT  present the word until the consumer accepts it
//   On acceptance, pc either advances by one (wrapping) or takes a jump target.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          asynchronous active-high reset
//   rom_read     read strobe to the program ROM (high only in S_REQ)
//   rom_addr     ROM address, always equal to pc
//   rom_data     ROM read data, valid the cycle after rom_read
//   instr_out    fetched instruction word
//   instr_valid  instr_out holds a valid instruction (high only in S_OUT)
//   instr_ready  consumer accepts instr_out
//   jump_en      redirect request, honoured only on the S_OUT handshake
//   jump_addr    redirect target
//   pc_out       address of the word currently held or being fetched
//   halted       fetch stopped until reset (high only in S_HALT)
//
// Configuration:
//   FETCH_HALT_ON_ZERO_EN  when defined, a fetched all-zero word stops the
//                          unit in S_HALT instead of being delivered. When
//                          undefined, halted is tied low and a zero word is
//                          an ordinary instruction.
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int                 ADDR_W   = 8,
    parameter int                 DATA_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_read,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] instr_out,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted
);

`ifdef FETCH_HALT_ON_ZERO_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_CAP,
        S_OUT,
        S_HALT
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_CAP,
        S_OUT
    } state_t;
`endif

    state_t              state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [DATA_W-1:0]   instr_q;
    logic [ADDR_W-1:0]   pc_d;

    // Next pc taken on an accepted instruction: jump target or sequential
    // successor. The increment is truncated to ADDR_W so the top address
    // wraps back to zero.
    assign pc_d = jump_en ? jump_addr : pc_q + ADDR_W'(1);

    // Fetch sequencer. pc only moves on the S_OUT handshake, which keeps
    // rom_addr stable across the ROM's registered access in S_REQ/S_CAP.
    // Reset discards any in-flight word, since instr_q is cleared and the
    // sequence restarts from S_IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_REQ;
                end
                S_REQ: begin
                    state_q <= S_CAP;
                end
                S_CAP: begin
                    instr_q <= rom_data;
`ifdef FETCH_HALT_ON_ZERO_EN
                    if (rom_data == '0) begin
                        state_q <= S_HALT;
                    end else begin
                        state_q <= S_OUT;
                    end
`else
                    state_q <= S_OUT;
`endif
                end
                S_OUT: begin
                    if (instr_ready) begin
                        pc_q    <= pc_d;
                        state_q <= S_REQ;
                    end
                end
`ifdef FETCH_HALT_ON_ZERO_EN
                S_HALT: begin
                    state_q <= S_HALT;
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // All outputs are decoded directly from registered state, so they are
    // glitch-free and settle to reset values as soon as rst asserts.
    assign rom_read    = (state_q == S_REQ);
    assign rom_addr    = pc_q;
    assign pc_out      = pc_q;
    assign instr_out   = instr_q;
    assign instr_valid = (state_q == S_OUT);
`ifdef FETCH_HALT_ON_ZERO_EN
    assign halted      = (state_q == S_HALT);
`else
    assign halted      = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Purpose:
//   Directed self-checking bench for fetch_unit, driving it with a registered
//   ROM model. A table of per-cycle vectors covers stall, jump, wrap and the
//   zero-word behaviour; hand-written sequences cover reset latency,
//   steady-state throughput and an asynchronous reset during S_CAP.
//
// Configuration:
//   FETCH_HALT_ON_ZERO_EN  selects which zero-word expectations are used.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        romRead;
    logic [7:0]  romAddr;
    logic [15:0] romData;
    logic [15:0] instrOut;
    logic        instrValid;
    logic        instrReady;
    logic        jumpEn;
    logic [7:0]  jumpAddr;
    logic [7:0]  pcOut;
    logic        halted;

    logic [15:0] romMem [256];

    int totalChecks;
    int badChecks;

    typedef struct {
        string       name;
        logic        ready;
        logic        jumpEn;
        logic [7:0]  jumpAddr;
        logic        expValid;
        logic [15:0] expInstr;
        logic [7:0]  expPc;
        logic        expRead;
        logic        expHalted;
    } vec_t;

    vec_t vecs[$];

    fetch_unit #(
        .ADDR_W   (8),
        .DATA_W   (16),
        .RESET_PC (8'h00)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rom_read    (romRead),
        .rom_addr    (romAddr),
        .rom_data    (romData),
        .instr_out   (instrOut),
        .instr_valid (instrValid),
        .instr_ready (instrReady),
        .jump_en     (jumpEn),
        .jump_addr   (jumpAddr),
        .pc_out      (pcOut),
        .halted      (halted)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Registered ROM: data for the address presented with rom_read appears
    // on the following cycle.
    always @(posedge clk) begin
        if (romRead) begin
            romData <= romMem[romAddr];
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive inputs at the falling edge, let one rising edge pass, and return
    // at the next falling edge where outputs are stable.
    task automatic applyStimulus(input logic ready, input logic jen,
                                 input logic [7:0] jaddr);
        instrReady = ready;
        jumpEn     = jen;
        jumpAddr   = jaddr;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic addRow(input string name, input logic ready, input logic jen,
                          input logic [7:0] jaddr, input logic v,
                          input logic [15:0] instr, input logic [7:0] pc,
                          input logic rd, input logic h);
        vec_t row;
        row.name      = name;
        row.ready     = ready;
        row.jumpEn    = jen;
        row.jumpAddr  = jaddr;
        row.expValid  = v;
        row.expInstr  = instr;
        row.expPc     = pc;
        row.expRead   = rd;
        row.expHalted = h;
        vecs.push_back(row);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".valid"},  {15'd0, instrValid}, 16'd0);
        checkOutput({tag, ".read"},   {15'd0, romRead},    16'd0);
        checkOutput({tag, ".halted"}, {15'd0, halted},     16'd0);
        checkOutput({tag, ".pc"},     {8'd0, pcOut},       16'h0000);
        checkOutput({tag, ".instr"},  instrOut,            16'h0000);
    endtask

    // Hold reset across two falling edges and release on a falling edge,
    // leaving the DUT in S_IDLE.
    task automatic doReset();
        rst        = 1'b1;
        instrReady = 1'b0;
        jumpEn     = 1'b0;
        jumpAddr   = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Main test sequence: reset check, throughput, async reset, then table.
    initial begin
        logic [15:0] seqWords [3];
        totalChecks = 0;
        badChecks   = 0;
        romData     = 16'h0000;

        for (int a = 0; a < 256; a++) begin
            romMem[a] = {8'hA5, 8'(a)};
        end
        romMem[8'h00] = 16'h1042;
        romMem[8'h01] = 16'h2043;
        romMem[8'h02] = 16'h3044;
        romMem[8'h03] = 16'h0000;
        romMem[8'hFF] = 16'hC0CA;
        romMem[8'h10] = 16'hD0C1;

        seqWords[0] = 16'h1042;
        seqWords[1] = 16'h2043;
        seqWords[2] = 16'h3044;

        doReset();
        checkResetState("reset");

        // Ready held high: a word every third cycle, starting at cycle 3.
        for (int c = 1; c <= 11; c++) begin
            applyStimulus(1'b1, 1'b0, 8'h00);
            checkOutput($sformatf("stream.c%0d.valid", c), {15'd0, instrValid},
                        {15'd0, (c % 3 == 0)});
            if (c % 3 == 0) begin
                checkOutput($sformatf("stream.c%0d.instr", c), instrOut, seqWords[c/3-1]);
                checkOutput($sformatf("stream.c%0d.addr", c), {8'd0, romAddr},
                            16'(c/3 - 1));
            end
        end

        // Now in S_CAP at pc 03 with 3044 held; assert reset mid-cycle and
        // check the outputs before any further clock edge.
        #2;
        rst = 1'b1;
        #1;
        checkResetState("asyncRst");
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            applyStimulus(1'b1, 1'b0, 8'h00);
            checkOutput($sformatf("postRst.c%0d.valid", c), {15'd0, instrValid},
                        {15'd0, (c == 3)});
        end
        checkOutput("postRst.instr", instrOut, 16'h1042);
        checkOutput("postRst.pc", {8'd0, pcOut}, 16'h0000);

        // Per-cycle table: inputs for one cycle, expected outputs after it.
        addRow("idle2req",  1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0);
        addRow("reqJmpIgn", 1'b1, 1'b1, 8'h55, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0);
        addRow("capJmpIgn", 1'b1, 1'b1, 8'h55, 1'b1, 16'h1042, 8'h00, 1'b0, 1'b0);
        addRow("stall1",    1'b0, 1'b0, 8'h00, 1'b1, 16'h1042, 8'h00, 1'b0, 1'b0);
        addRow("stall2",    1'b0, 1'b0, 8'h00, 1'b1, 16'h1042, 8'h00, 1'b0, 1'b0);
        addRow("stall3Jmp", 1'b0, 1'b1, 8'h77, 1'b1, 16'h1042, 8'h00, 1'b0, 1'b0);
        addRow("stall4",    1'b0, 1'b0, 8'h00, 1'b1, 16'h1042, 8'h00, 1'b0, 1'b0);
        addRow("stall5",    1'b0, 1'b0, 8'h00, 1'b1, 16'h1042, 8'h00, 1'b0, 1'b0);
        addRow("jmp10",     1'b1, 1'b1, 8'h10, 1'b0, 16'h1042, 8'h10, 1'b1, 1'b0);
        addRow("jmp10Cap",  1'b0, 1'b0, 8'h00, 1'b0, 16'h1042, 8'h10, 1'b0, 1'b0);
        addRow("jmp10Out",  1'b0, 1'b0, 8'h00, 1'b1, 16'hD0C1, 8'h10, 1'b0, 1'b0);
        addRow("jmpFF",     1'b1, 1'b1, 8'hFF, 1'b0, 16'hD0C1, 8'hFF, 1'b1, 1'b0);
        addRow("jmpFFCap",  1'b1, 1'b0, 8'h00, 1'b0, 16'hD0C1, 8'hFF, 1'b0, 1'b0);
        addRow("jmpFFOut",  1'b0, 1'b0, 8'h00, 1'b1, 16'hC0CA, 8'hFF, 1'b0, 1'b0);
        addRow("wrapReq",   1'b1, 1'b0, 8'h00, 1'b0, 16'hC0CA, 8'h00, 1'b1, 1'b0);
        addRow("wrapCap",   1'b1, 1'b0, 8'h00, 1'b0, 16'hC0CA, 8'h00, 1'b0, 1'b0);
        addRow("wrapOut",   1'b0, 1'b0, 8'h00, 1'b1, 16'h1042, 8'h00, 1'b0, 1'b0);
        addRow("seq01Req",  1'b1, 1'b0, 8'h00, 1'b0, 16'h1042, 8'h01, 1'b1, 1'b0);
        addRow("seq01Cap",  1'b1, 1'b0, 8'h00, 1'b0, 16'h1042, 8'h01, 1'b0, 1'b0);
        addRow("seq01Out",  1'b1, 1'b0, 8'h00, 1'b1, 16'h2043, 8'h01, 1'b0, 1'b0);
        addRow("seq02Req",  1'b1, 1'b0, 8'h00, 1'b0, 16'h2043, 8'h02, 1'b1, 1'b0);
        addRow("seq02Cap",  1'b1, 1'b0, 8'h00, 1'b0, 16'h2043, 8'h02, 1'b0, 1'b0);
        addRow("seq02Out",  1'b1, 1'b0, 8'h00, 1'b1, 16'h3044, 8'h02, 1'b0, 1'b0);
        addRow("seq03Req",  1'b1, 1'b0, 8'h00, 1'b0, 16'h3044, 8'h03, 1'b1, 1'b0);
        addRow("seq03Cap",  1'b1, 1'b0, 8'h00, 1'b0, 16'h3044, 8'h03, 1'b0, 1'b0);
`ifdef FETCH_HALT_ON_ZERO_EN
        addRow("halt",      1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h03, 1'b0, 1'b1);
        addRow("haltJmp",   1'b1, 1'b1, 8'h10, 1'b0, 16'h0000, 8'h03, 1'b0, 1'b1);
        addRow("haltHold1", 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h03, 1'b0, 1'b1);
        addRow("haltHold2", 1'b0, 1'b1, 8'hFF, 1'b0, 16'h0000, 8'h03, 1'b0, 1'b1);
`else
        addRow("zeroOut",   1'b1, 1'b0, 8'h00, 1'b1, 16'h0000, 8'h03, 1'b0, 1'b0);
        addRow("seq04Req",  1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h04, 1'b1, 1'b0);
        addRow("seq04Cap",  1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h04, 1'b0, 1'b0);
        addRow("seq04Out",  1'b0, 1'b0, 8'h00, 1'b1, 16'hA504, 8'h04, 1'b0, 1'b0);
`endif

        doReset();
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].ready, vecs[i].jumpEn, vecs[i].jumpAddr);
            checkOutput({vecs[i].name, ".valid"},  {15'd0, instrValid}, {15'd0, vecs[i].expValid});
            checkOutput({vecs[i].name, ".instr"},  instrOut, vecs[i].expInstr);
            checkOutput({vecs[i].name, ".pc"},     {8'd0, pcOut}, {8'd0, vecs[i].expPc});
            checkOutput({vecs[i].name, ".addr"},   {8'd0, romAddr}, {8'd0, vecs[i].expPc});
            checkOutput({vecs[i].name, ".read"},   {15'd0, romRead}, {15'd0, vecs[i].expRead});
            checkOutput({vecs[i].name, ".halted"}, {15'd0, halted}, {15'd0, vecs[i].expHalted});
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ADDR_W, 8, program address width.
- DATA_W, 16, instruction word width.
- RESET_PC, 0, PC value loaded by reset.

REQ-002 Ports, one per line: name, direction, width, meaning. Clock and reset are listed first.
- clk, in, 1, single clock; all state changes on rising edge.
- rst, in, 1, reset; asynchronous, active-high.
- rom_read, out, 1, read strobe to program ROM.
- rom_addr, out, ADDR_W, ROM address.
- rom_data, in, DATA_W, ROM read data; registered by ROM, valid the cycle after rom_read.
- instr_out, out, DATA_W, fetched instruction word.
- instr_valid, out, 1, instr_out holds a valid instruction.
- instr_ready, in, 1, consumer accepts instr_out.
- jump_en, in, 1, redirect request.
- jump_addr, in, ADDR_W, redirect target.
- pc_out, out, ADDR_W, address of the word currently held or being fetched.
- halted, out, 1, fetch stopped permanently until reset.

Function
REQ-003 Four states: S_IDLE, S_REQ, S_CAP, S_OUT; a fifth state, S_HALT, exists only when FETCH_HALT_ON_ZERO_EN is defined.
REQ-004 Outputs decoded from state:
- rom_read = 1 only in S_REQ.
- rom_addr = pc in all states.
- instr_valid = 1 only in S_OUT.
- halted = 1 only in S_HALT.
REQ-005 State transitions:
- S_IDLE -> S_REQ unconditionally, one cycle after reset release.
- S_REQ -> S_CAP unconditionally.
- S_CAP: capture rom_data into instr_out at the end of the cycle, then go to S_OUT.
REQ-006 S_OUT holds instr_out and pc stable until the handshake (instr_valid & instr_ready), then goes to S_REQ.
REQ-007 On the handshake cycle:
- jump_en=1: pc <= jump_addr.
- jump_en=0: pc <= pc+1, modulo 2^ADDR_W, so 8'hFF wraps to 8'h00.
REQ-008 jump_en outside the S_OUT handshake cycle is ignored and does not alter pc.
REQ-009 pc never changes in S_REQ or S_CAP, so rom_addr is stable across the ROM's registered access.
REQ-010 Latency and throughput:
- First instr_valid occurs in the 3rd cycle after reset release.
- With instr_ready held high, one instruction is delivered every 3 cycles.
REQ-011 pc_out = pc at all times.

Reset
REQ-012 Asserting rst forces, immediately and without waiting for clk:
- state = S_IDLE, pc = RESET_PC, instr_out = 0.
- rom_read = 0, instr_valid = 0, halted = 0.
REQ-013 rst asserted mid-fetch (S_REQ/S_CAP) or mid-handshake discards the in-flight word; no instr_valid pulse follows release until a fresh fetch completes.

Configuration
REQ-014 The compile-time macro FETCH_HALT_ON_ZERO_EN controls handling of a zero word.
- Defined: a captured rom_data == 0 sends S_CAP -> S_HALT instead of S_OUT; instr_valid stays 0; instr_out is loaded with 0; pc is not incremented.
- Defined: S_HALT ignores jump_en and instr_ready, keeps rom_read=0, and is left only by rst.
- Not defined: S_HALT does not exist, halted is tied to 0, and a zero word is delivered as an ordinary instruction.

Verification
REQ-015 The bench shall use a registered ROM model with:
- 00=16'h1042, 01=16'h2043, 02=16'h3044, 03=16'h0000.
- FF=16'hC0CA, 10=16'hD0C1.
REQ-016 The bench shall cover these directed scenarios:
- Reset then instr_ready=1 -> instr_valid at cycles 3, 6, 9 with 16'h1042, 16'h2043, 16'h3044; rom_addr 00, 01, 02.
- instr_ready=0 for 5 cycles in S_OUT with word 16'h1042 -> instr_valid, instr_out and pc_out=00 held; rom_read=0 throughout.
- jump_en=1, jump_addr=8'h10 on handshake of word at 00 -> next rom_addr=8'h10, next instr_out=16'hD0C1.
- Jump to 8'hFF, accept 16'hC0CA -> pc wraps to 8'h00, next word 16'h1042.
- Macro defined, fetch reaches 03 -> halted=1, instr_valid=0, pc_out=03 indefinitely. Macro undefined -> 16'h0000 delivered with instr_valid=1 and pc advances to 04.
- rst pulsed asynchronously during S_CAP -> outputs reach reset values before the next edge; first post-reset word is 16'h1042.
- jump_en=1 during S_REQ -> ignored; sequence unchanged.
